cpu_step_ctrl: RTL and testbench

- Run-control block for the single-cycle CPU on the FPGA board.
- Drives a one-cycle clock-enable pulse, cpu_en, to the CPU, which always runs on clk. No derived clock is generated.
- Modes: free-run fast, free-run slow, or single-step from a raw push-button.
- Also provides a debounced button level and a count of issued steps for the display.

---
 rtl/cpu_ctrl_pkg.sv | 8 +
 rtl/btn_debounce.sv | 81 ++++++++
 rtl/cpu_step_ctrl.sv | 79 +++++++
 tb/tb_cpu_step_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default constants for the CPU run-control block.
package cpu_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;

   localparam int unsigned FAST_DIV_DEF  = 8;
   localparam int unsigned SLOW_DIV_DEF  = 67108864;
   localparam int unsigned DB_CYCLES_DEF = 1000000;
endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debounce FSM: a stable level plus a single
// press pulse, asserted combinationally in the cycle the press is accepted.
module btn_debounce
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic press_pulse
);
   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync;
   logic          btn_s;
   db_state_t     state, state_nxt;
   logic [CW-1:0] db_cnt, cnt_nxt;
   logic          level_nxt;

   assign btn_s = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync   <= '0;
         state  <= IDLE;
         db_cnt <= '0;
         level  <= 1'b0;
      end else begin
         sync   <= {sync[0], btn};
         state  <= state_nxt;
         db_cnt <= cnt_nxt;
         level  <= level_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = db_cnt;
      level_nxt   = level;
      press_pulse = 1'b0;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_nxt = IDLE;
            end else if (db_cnt == LAST) begin
               state_nxt   = PRESSED;
               level_nxt   = 1'b1;
               press_pulse = 1'b1;
            end else begin
               cnt_nxt = db_cnt + CW'(1);
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_nxt = RELEASE_WAIT;
               cnt_nxt   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s) begin
               state_nxt = PRESSED;
            end else if (db_cnt == LAST) begin
               state_nxt = IDLE;
               level_nxt = 1'b0;
            end else begin
               cnt_nxt = db_cnt + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: rtl/cpu_step_ctrl.sv
// Run control for the single-cycle CPU: emits a one-cycle cpu_en strobe in
// fast/slow free-run or debounced single-step mode, and counts issued steps.
module cpu_step_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned FAST_DIV  = FAST_DIV_DEF,
   parameter int unsigned SLOW_DIV  = SLOW_DIV_DEF,
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sw_slow,
   input  logic        sw_step,
   input  logic        btn_step,
   input  logic        halt,
   output logic        cpu_en,
   output logic        btn_db,
   output logic [31:0] step_cnt
);
   localparam int unsigned MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
   localparam int DW = $clog2(MAX_DIV);

   logic [1:0]    slow_sync, step_sync;
   logic          slow_q;
   logic          slow_s, step_s;
   logic          step_req;
   logic [DW-1:0] div_cnt, div_nxt, period_last;
   logic          en_nxt;

   assign slow_s      = slow_sync[1];
   assign step_s      = step_sync[1];
   assign period_last = slow_s ? DW'(SLOW_DIV - 1) : DW'(FAST_DIV - 1);

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn_step),
      .level       (btn_db),
      .press_pulse (step_req)
   );

   // A period switch restarts the divider so the new rate begins on a clean boundary.
   always_comb begin
      div_nxt = div_cnt;
      en_nxt  = 1'b0;
      if (slow_s != slow_q) begin
         div_nxt = '0;
      end else if (step_s) begin
         div_nxt = '0;
         en_nxt  = step_req & ~halt;
      end else if (!halt) begin
         if (div_cnt == period_last) begin
            div_nxt = '0;
            en_nxt  = 1'b1;
         end else begin
            div_nxt = div_cnt + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slow_sync <= '0;
         step_sync <= '0;
         slow_q    <= 1'b0;
         div_cnt   <= '0;
         cpu_en    <= 1'b0;
         step_cnt  <= '0;
      end else begin
         slow_sync <= {slow_sync[0], sw_slow};
         step_sync <= {step_sync[0], sw_step};
         slow_q    <= slow_s;
         div_cnt   <= div_nxt;
         // Masking with the current strobe keeps pulses apart across mode switches.
         cpu_en    <= en_nxt & ~cpu_en;
         if (cpu_en) step_cnt <= step_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: directed table, corner-case sequences,
// and randomized stimulus against a behavioural reference model.
module tb_cpu_step_ctrl;
   import cpu_ctrl_pkg::*;

   localparam int FAST = 4;
   localparam int SLOW = 16;
   localparam int DB   = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sw_slow = 1'b0, sw_step = 1'b0, btn_step = 1'b0, halt = 1'b0;
   logic        cpu_en, btn_db;
   logic [31:0] step_cnt;

   int checks = 0;
   int errors = 0;

   cpu_step_ctrl #(.FAST_DIV(FAST), .SLOW_DIV(SLOW), .DB_CYCLES(DB)) dut (
      .clk      (clk),
      .rst      (rst),
      .sw_slow  (sw_slow),
      .sw_step  (sw_step),
      .btn_step (btn_step),
      .halt     (halt),
      .cpu_en   (cpu_en),
      .btn_db   (btn_db),
      .step_cnt (step_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: raw-input histories give the synchronized views, the
   // button is accepted after DB+1 consecutive opposite samples, and free-run
   // pulses land on multiples of the period in counted (non-halted) cycles.
   bit          qs[$], qp[$], qb[$];
   logic        m_en, m_lvl;
   int          m_run, m_act;
   logic [31:0] m_cnt;

   task automatic model_reset();
      qs.delete(); qp.delete(); qb.delete();
      repeat (3) begin qs.push_back(1'b0); qp.push_back(1'b0); qb.push_back(1'b0); end
      m_en = 1'b0; m_lvl = 1'b0; m_run = 0; m_act = 0; m_cnt = '0;
   endtask

   task automatic model_edge(input bit slow, input bit step, input bit btn, input bit hlt);
      bit s_slow, s_prev, s_step, s_btn, req, en;
      int per;
      s_slow = qs[$-1]; s_prev = qs[$-2]; s_step = qp[$-1]; s_btn = qb[$-1];
      qs.push_back(slow); qp.push_back(step); qb.push_back(btn);
      void'(qs.pop_front()); void'(qp.pop_front()); void'(qb.pop_front());
      if (m_en) m_cnt = m_cnt + 32'd1;
      req = 1'b0;
      if (s_btn != m_lvl) begin
         m_run++;
         if (m_run == DB + 1) begin
            m_lvl = s_btn; m_run = 0; req = s_btn;
         end
      end else begin
         m_run = 0;
      end
      per = s_slow ? SLOW : FAST;
      en  = 1'b0;
      if (s_slow != s_prev) m_act = 0;
      else if (s_step) begin m_act = 0; en = req && !hlt; end
      else if (!hlt) begin m_act++; en = (m_act % per == 0); end
      m_en = en && !m_en;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic prev;
      prev = cpu_en;
      model_edge(sw_slow, sw_step, btn_step, halt);
      @(posedge clk);
      @(negedge clk);
      chk("cpu_en", cpu_en, m_en);
      chk("btn_db", btn_db, m_lvl);
      chk("step_cnt", step_cnt, m_cnt);
      chk("b2b_en", prev & cpu_en, 0);
   endtask

   typedef struct {
      logic        slow, step, hlt, btn;
      logic        exp_en;
      logic [31:0] exp_cnt;
   } vec_t;
   vec_t tbl[20];

   initial begin
      int first, second, n, e, run;
      bit found;

      // Table: edge e after reset release, fast mode, pulses in cycles 5,9,13,17.
      for (int k = 0; k < 20; k++) begin
         e = k + 1;
         tbl[k].slow = 1'b0; tbl[k].step = 1'b0; tbl[k].hlt = 1'b0; tbl[k].btn = 1'b0;
         tbl[k].exp_en  = (e >= 4) && (e % 4 == 0);
         tbl[k].exp_cnt = (e >= 5) ? 32'((e - 5) / 4 + 1) : 32'd0;
      end

      repeat (3) @(negedge clk);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_btn_db", btn_db, 0);
      chk("rst_step_cnt", step_cnt, 0);
      chk("rst_fsm", dut.u_db.state, IDLE);
      model_reset();
      rst = 1'b0;

      for (int k = 0; k < 20; k++) begin
         sw_slow = tbl[k].slow; sw_step = tbl[k].step; halt = tbl[k].hlt; btn_step = tbl[k].btn;
         tick();
         chk($sformatf("tbl_en[%0d]", k), cpu_en, tbl[k].exp_en);
         chk($sformatf("tbl_cnt[%0d]", k), step_cnt, tbl[k].exp_cnt);
      end

      // Switch to slow mid-period: restart, then a pulse every 16 cycles.
      sw_slow = 1'b1; first = -1; second = -1; n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (cpu_en) begin
            n++;
            if (n == 1) first = i;
            if (n == 2) second = i;
         end
      end
      chk("slow_first", first, 19);
      chk("slow_second", second, 35);
      chk("slow_npulse", n, 2);

      // Step mode, bouncing button: never accepted.
      sw_step = 1'b1;
      repeat (6) tick();
      run = int'(m_cnt); n = 0; found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         btn_step = ((i / 3) % 2 == 0);
         tick();
         n += int'(cpu_en); found |= btn_db;
      end
      btn_step = 1'b0;
      repeat (20) begin tick(); n += int'(cpu_en); found |= btn_db; end
      chk("bounce_npulse", n, 0);
      chk("bounce_btn_db", found, 0);
      chk("bounce_cnt", step_cnt, run);

      // Held button: one step, 2+8+1 cycles after the press.
      btn_step = 1'b1; first = -1; n = 0;
      for (int i = 1; i <= 50; i++) begin
         tick();
         if (cpu_en) begin n++; if (first < 0) first = i; end
      end
      chk("hold_first", first, 11);
      chk("hold_npulse", n, 1);
      chk("hold_btn_db", btn_db, 1);
      chk("hold_cnt", step_cnt, run + 1);
      btn_step = 1'b0;
      repeat (15) tick();
      chk("release_btn_db", btn_db, 0);

      // Halt in fast mode starting at div_cnt=2.
      sw_step = 1'b0; sw_slow = 1'b0;
      repeat (10) tick();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin tick(); found = cpu_en; end
      chk("halt_sync", found, 1);
      tick(); tick();
      halt = 1'b1; n = 0;
      repeat (10) begin tick(); n += int'(cpu_en); end
      chk("halt_quiet", n, 0);
      halt = 1'b0; first = -1;
      for (int i = 1; i <= 6; i++) begin tick(); if (cpu_en && first < 0) first = i; end
      chk("halt_resume", first, 2);

      // Step counter wrap.
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin tick(); found = cpu_en; end
      tick();
      force dut.step_cnt = 32'hFFFF_FFFF;
      #1 release dut.step_cnt;
      m_cnt = 32'hFFFF_FFFF;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin tick(); found = cpu_en; end
      chk("wrap_sync", found, 1);
      tick();
      chk("wrap_cnt", step_cnt, 0);

      // Reset while the debounce FSM is qualifying a press.
      sw_step = 1'b1;
      repeat (6) tick();
      btn_step = 1'b1;
      repeat (6) tick();
      #2 rst = 1'b1;
      #1;
      chk("arst_cpu_en", cpu_en, 0);
      chk("arst_btn_db", btn_db, 0);
      chk("arst_step_cnt", step_cnt, 0);
      chk("arst_fsm", dut.u_db.state, IDLE);
      @(negedge clk); @(negedge clk);
      model_reset();
      rst = 1'b0;
      first = -1; n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (cpu_en) begin n++; if (first < 0) first = i; end
      end
      chk("requal_first", first, 11);
      chk("requal_npulse", n, 1);

      // Randomized run against the model.
      run = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) sw_slow = ~sw_slow;
         if ($urandom_range(0, 149) == 0) sw_step = ~sw_step;
         halt = ($urandom_range(0, 9) == 0);
         if (run == 0) begin
            btn_step = 1'($urandom_range(0, 1));
            run = $urandom_range(1, 24);
         end
         run--;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
